// File: rtl/adc_serial_rx.sv
// adc_serial_rx: periodic serial ADC frame reader feeding the lowpass FIR stage.
//
// A free-running sample counter produces one tick every SAMPLE_PERIOD clocks while
// enabled. Each tick runs one conversion frame: chip select low, CLK_DIV cycles of
// setup, then DATA_WIDTH serial clock pulses (CLK_DIV low + CLK_DIV high each), with
// adc_sdata captured MSB first. The finished word is presented on dataout together
// with a one-cycle endata strobe.
//
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous, active-high
//   enable     1 = periodic conversions run; a frame in flight always completes
//   adc_cs_n   ADC chip select, active low
//   adc_sclk   ADC serial clock, idles low
//   adc_sdata  ADC serial data, MSB first
//   dataout    last completed sample (two's complement), held between updates
//   endata     one-cycle strobe: dataout updated this cycle
//   overrun    sticky: a tick arrived while a frame was still busy
module adc_serial_rx #(
    parameter int unsigned DATA_WIDTH    = 18,
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned SAMPLE_PERIOD = 2500
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    output logic                  adc_cs_n,
    output logic                  adc_sclk,
    input  logic                  adc_sdata,
    output logic [DATA_WIDTH-1:0] dataout,
    output logic                  endata,
    output logic                  overrun
);

    localparam int unsigned CntW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CntW-1:0] CntLast = CntW'(SAMPLE_PERIOD - 1);
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StShift,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [DivW-1:0]         div_q, div_d;
    logic [BitW-1:0]         bit_q, bit_d;
    logic                    phase_q, phase_d;   // sclk level within a bit-period
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    tick;
    logic                    sample_en;

    logic                    cs_n_q;
    logic                    sclk_q;
    logic [DATA_WIDTH-1:0]   dataout_q;
    logic                    endata_q;
    logic                    overrun_q;

    // Sample-rate counter: held at zero while disabled so re-enabling gives a full period.
    always_comb begin
        cnt_d = '0;
        if (enable) begin
            cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick = enable && (cnt_q == CntLast);

    // Capture on the first cycle of every sclk-high half.
    assign sample_en = (state_q == StShift) && phase_q && (div_q == '0);

    always_comb begin
        shift_d = shift_q;
        if (sample_en) begin
            shift_d = {shift_q[DATA_WIDTH-2:0], adc_sdata};
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        case (state_q)
            StIdle: begin
                if (tick) begin
                    state_d = StSetup;
                    div_d   = '0;
                end
            end
            StSetup: begin
                if (div_q == DivLast) begin
                    state_d = StShift;
                    div_d   = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StShift: begin
                if (div_q == DivLast) begin
                    div_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else if (bit_q == BitLast) begin
                        phase_d = 1'b0;
                        state_d = StDone;
                    end else begin
                        phase_d = 1'b0;
                        bit_d   = bit_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            div_q     <= '0;
            bit_q     <= '0;
            phase_q   <= 1'b0;
            shift_q   <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            dataout_q <= '0;
            endata_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            phase_q   <= phase_d;
            shift_q   <= shift_d;
            cs_n_q    <= !((state_d == StSetup) || (state_d == StShift));
            sclk_q    <= (state_d == StShift) && phase_d;
            endata_q  <= (state_d == StDone);
            // shift_d, not shift_q: with CLK_DIV=1 the last bit lands on this same edge.
            if (state_d == StDone) begin
                dataout_q <= shift_d;
            end
            if (tick && (state_q != StIdle)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign adc_cs_n = cs_n_q;
    assign adc_sclk = sclk_q;
    assign dataout  = dataout_q;
    assign endata   = endata_q;
    assign overrun  = overrun_q;

endmodule

// File: doc/adc_serial_rx.md
Name: adc_serial_rx

Overview:
Upstream front end for the lowpass FIR stage. It periodically runs a serial ADC conversion frame (chip select, serial clock, 18 bits MSB first) and presents each sample as a parallel 18-bit two's-complement word. A one-cycle endata strobe per sample drives the filter's datain/endata inputs directly. The block also sets the system sample rate.

Parameters:
DATA_WIDTH, 18, sample width; matches the filter datain.
CLK_DIV, 4, system clocks per adc_sclk half-period (>=1).
SAMPLE_PERIOD, 2500, system clocks between conversion starts (e.g. 100 MHz / 40 kHz).

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high.
enable  in  1  1 = periodic conversions run.
adc_cs_n  out  1  ADC chip select, active low.
adc_sclk  out  1  ADC serial clock, idles low.
adc_sdata  in  1  ADC serial data, MSB first.
dataout  out  DATA_WIDTH  last completed sample; held between updates.
endata  out  1  one-cycle strobe: dataout updated this cycle.
overrun  out  1  sticky error: a tick arrived while a frame was busy.

Behaviour:
- All outputs are registered. Reset values: adc_cs_n=1, adc_sclk=0, dataout=0, endata=0, overrun=0. State=IDLE, sample counter=0.
- Reset mid-frame aborts the frame immediately: no endata, dataout=0, cs_n high on the next edge.
- Sample counter:
  - When enable=1, it counts 0..SAMPLE_PERIOD-1 and wraps.
  - A "tick" is the cycle in which count==SAMPLE_PERIOD-1.
  - When enable=0, the counter is held at 0 and no ticks occur.
  - A frame already in progress when enable drops still completes.
- FSM states: IDLE, SETUP, SHIFT, DONE.
  - IDLE: cs_n=1, sclk=0. A tick moves the FSM to SETUP.
  - SETUP: cs_n=0, sclk=0 for CLK_DIV cycles, then SHIFT.
  - SHIFT: 18 bit-periods. Each bit-period is CLK_DIV cycles with sclk=0, then CLK_DIV cycles with sclk=1. cs_n stays 0.
  - adc_sdata is sampled in the first cycle of each sclk-high half and shifted into the LSB of an internal shift register (MSB first overall).
  - A bit counter 0..17 ends SHIFT after bit 17's high half, then DONE.
  - DONE (1 cycle): cs_n=1, sclk=0, dataout<=shift register, endata=1. Next state IDLE.
- Latency: tick in cycle T gives cs_n low from T+1 and endata high at T+37*CLK_DIV+1. With CLK_DIV=2 that is T+75.
- Frame length is 37*CLK_DIV+1 cycles. SAMPLE_PERIOD must exceed it. The filter additionally needs about 68 cycles per sample, so SAMPLE_PERIOD >= 37*CLK_DIV+70.
- A tick in any state other than IDLE (including DONE) is ignored and sets overrun. Overrun clears only on reset. The current frame is unaffected.
- endata is high only in the DONE cycle. dataout never changes outside DONE or reset.
- No arithmetic on data: bits are passed through unchanged, sign included (bit 17 = sign).

Test Plan:
- Reset, then enable=1, CLK_DIV=2, SAMPLE_PERIOD=200; ADC model drives 0x2A5A5 MSB first on sclk falling edges -> at tick+75 cycles dataout=0x2A5A5, endata high exactly 1 cycle; cs_n low for 74 cycles; 18 sclk pulses, each 2 high / 2 low.
- Back-to-back samples 0x20000 then 0x1FFFF -> endata strobes exactly 200 cycles apart; dataout=0x20000 (most negative) held until it becomes 0x1FFFF.
- SAMPLE_PERIOD=60, CLK_DIV=2 (frame 75 > 60) -> overrun=1 after the second tick; frames still complete with correct data; overrun stays 1 until reset.
- Assert reset at bit 9 of a frame -> next edge: cs_n=1, sclk=0, dataout=0, no endata; after release with enable=1, first endata at 200+75 cycles with correct data.
- Drop enable mid-frame -> current frame completes with endata; no further cs_n activity; re-enable -> first tick 200 cycles later.
- Compare against the FIR block: endata/dataout wired to the filter's endata/datain -> filter accepts every sample (no endata while filter busy at SAMPLE_PERIOD=200).
